// File: rtl/jtopl_slot_tap_if.sv
// Host-side bus of the slot tap: capture control/status plus the random-access read port.
// The tap drives the slave modport; the host (debug readback or harness) drives the master modport.
interface jtopl_slot_tap_if #(
    parameter int width = 10
);
    // rd_en is a one-shot strobe with no back-pressure (no ready).
    // Each rd_en gives exactly one rd_valid pulse one clk later.
    // rd_data is meaningful only while rd_valid is high.
    logic             snap_req;
    logic             busy;
    logic             done;
    logic             err;
    logic             rd_en;
    logic [4:0]       rd_addr;
    logic [width-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output snap_req, rd_en, rd_addr,
        input  busy, done, err, rd_data, rd_valid
    );

    modport slave (
        input  snap_req, rd_en, rd_addr,
        output busy, done, err, rd_data, rd_valid
    );
endinterface

// File: rtl/jtopl_slot_tap.sv
// Captures one aligned rotation of a per-slot shift ring and serves random-access reads of it.
// Optional macro JTOPL_SLOT_TAP_CHK_EN adds a sticky zero-cadence checker on err.
module jtopl_slot_tap #(
    parameter int width  = 10,
    parameter int stages = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             zero,
    input  logic [width-1:0] din,
    jtopl_slot_tap_if.slave  bus,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST = 5'(stages - 1);

    state_t           state;
    logic [4:0]       cnt;
    logic [width-1:0] mem [0:stages-1];
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic             in_range;

    assign fsm_state = state;
    assign in_range  = (int'(bus.rd_addr) < stages);

    // A zero inside CAPT means the ring slipped: it restarts at slot 0.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt;
        if (cen) begin
            if (state == ARM && zero) begin
                wr_en   = 1'b1;
                wr_addr = 5'd0;
            end else if (state == CAPT) begin
                wr_en   = 1'b1;
                wr_addr = zero ? 5'd0 : cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.snap_req) begin
                        state    <= ARM;
                        bus.busy <= 1'b1;
                        bus.done <= 1'b0;
                    end
                end
                ARM: begin
                    if (cen && zero) begin
                        state <= CAPT;
                        cnt   <= 5'd1;
                    end
                end
                CAPT: begin
                    if (cen) begin
                        if (zero) begin
                            cnt <= 5'd1;
                        end else if (cnt == LAST) begin
                            state    <= DONE;
                            cnt      <= 5'd0;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read sees pre-edge contents, so a same-edge write to that slot returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= in_range ? mem[bus.rd_addr] : '0;
        end
    end

`ifdef JTOPL_SLOT_TAP_CHK_EN
    logic err_q;
    logic post_chk;

    // post_chk covers only the first cen cycle spent in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            post_chk <= 1'b0;
        end else begin
            if (state == CAPT && cen && zero && cnt != 5'd0) err_q <= 1'b1;
            if (state == DONE && post_chk && cen && !zero) err_q <= 1'b1;
            if (state == CAPT && cen && !zero && cnt == LAST) post_chk <= 1'b1;
            else if (state != DONE || cen) post_chk <= 1'b0;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_jtopl_slot_tap.sv
// Randomized bench for jtopl_slot_tap against a queue-based capture model of the ring.
// Build with +define+JTOPL_SLOT_TAP_CHK_EN to also model the err checker.
module tb_jtopl_slot_tap;
    localparam int W = 10;
    localparam int S = 18;

    // ---------------- clock / reset ----------------
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         cen   = 1'b0;
    logic         zero  = 1'b0;
    logic [W-1:0] din   = '0;
    logic [1:0]   fsm_state;

    jtopl_slot_tap_if #(.width(W)) bus ();

    jtopl_slot_tap #(.width(W), .stages(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .zero      (zero),
        .din       (din),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_q holds the slot values of the rotation being captured, in arrival order.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_mem   [32];
    bit           m_known [32];
    bit           m_busy, m_done, m_err, m_post;

    function automatic void model_reset();
        m_busy = 0;
        m_done = 0;
        m_err  = 0;
        m_post = 0;
        m_q.delete();
    endfunction

    function automatic void model_edge(bit c, bit z, logic [W-1:0] v, bit sr);
        int idx;
        if (m_post && !m_busy && c) begin
`ifdef JTOPL_SLOT_TAP_CHK_EN
            if (!z) m_err = 1;
`endif
            m_post = 0;
        end
        if (!m_busy) begin
            if (sr) begin
                m_busy = 1;
                m_done = 0;
                m_post = 0;
                m_q.delete();
            end
        end else if (c) begin
            if (z) begin
`ifdef JTOPL_SLOT_TAP_CHK_EN
                if (m_q.size() > 0) m_err = 1;
`endif
                m_q.delete();
            end
            if (z || m_q.size() > 0) begin
                m_q.push_back(v);
                idx = m_q.size() - 1;
                m_mem[idx]   = v;
                m_known[idx] = 1;
            end
            if (m_q.size() == S) begin
                m_busy = 0;
                m_done = 1;
                m_post = 1;
            end
        end
    endfunction

    // ---------------- ring driver ----------------
    logic [W-1:0] ring_val [S];
    int           ring_slot = 0;
    bit           rand_fill = 0;

    task automatic cycle(input bit c, input bit z, input logic [W-1:0] v,
                         input bit re, input logic [4:0] ra, input bit sr);
        logic [W-1:0] exp_rd;
        bit           chk_rd;
        cen          = c;
        zero         = z;
        din          = v;
        bus.rd_en    = re;
        bus.rd_addr  = ra;
        bus.snap_req = sr;
        chk_rd = re && (int'(ra) >= S || m_known[ra]);
        exp_rd = (int'(ra) >= S) ? '0 : m_mem[ra];
        @(posedge clk);
        model_edge(c, z, v, sr);
        #1;
        check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, re});
        if (chk_rd) check($sformatf("rd_data[%0d]", ra), {22'd0, bus.rd_data}, {22'd0, exp_rd});
        check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        check("done", {31'd0, bus.done}, {31'd0, m_done});
        check("err",  {31'd0, bus.err},  {31'd0, m_err});
        cen          = 1'b0;
        zero         = 1'b0;
        bus.rd_en    = 1'b0;
        bus.snap_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, '0, 0, 5'd0, 0);
    endtask

    // One ring slot on a cen cycle, followed by gap cycles with cen low.
    task automatic beat(input int gap, input bit re, input logic [4:0] ra);
        cycle(1, ring_slot == 0, ring_val[ring_slot], re, ra, 0);
        ring_slot = (ring_slot + 1) % S;
        if (ring_slot == 0 && rand_fill)
            for (int k = 0; k < S; k++) ring_val[k] = ring_val[k] ^ W'($urandom_range(1, (1 << W) - 1));
        idle(gap);
    endtask

    task automatic snap();
        cycle(0, 0, '0, 0, 5'd0, 1);
    endtask

    task automatic run_to_done(input bit rnd_gap);
        for (int i = 0; i < 80 && !bus.done; i++)
            beat(rnd_gap ? $urandom_range(0, 3) : 3, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        check("done_reached", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic read_all();
        for (int k = 0; k < S; k++) cycle(0, 0, '0, 1, 5'(k), 0);
        cycle(0, 0, '0, 1, 5'd20, 0);
        repeat (8) cycle(0, 0, '0, 1, 5'($urandom_range(0, 31)), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.snap_req = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = 5'd0;
        for (int k = 0; k < 32; k++) m_known[k] = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_rd_data", {22'd0, bus.rd_data}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        idle(2);
        cycle(0, 0, '0, 1, 5'd3, 0);
        idle(1);

        // Aligned ring, din = slot + 0x100, cen every 4th clk
        for (int k = 0; k < S; k++) ring_val[k] = W'(12'h100 + k);
        ring_slot = 7;
        snap();
        run_to_done(0);
        cycle(0, 0, '0, 1, 5'd0, 0);
        check("slot0_const", {22'd0, bus.rd_data}, 32'h100);
        cycle(0, 0, '0, 1, 5'd17, 0);
        check("slot17_const", {22'd0, bus.rd_data}, 32'h111);
        read_all();

        // Random ring values, random cen gaps
        rand_fill = 1;
        for (int r = 0; r < 3; r++) begin
            snap();
            idle($urandom_range(0, 5));
            run_to_done(1);
            read_all();
        end

        // Misaligned zero at slot 5 during capture restarts it
        snap();
        while (ring_slot != 0) beat(1, 0, 5'd0);
        while (ring_slot != 5) beat(1, 0, 5'd0);
        ring_slot = 0;
        run_to_done(0);
        read_all();

        // Reset at slot 9 of a capture
        snap();
        while (ring_slot != 0) beat(1, 0, 5'd0);
        while (ring_slot != 10) beat(1, 0, 5'd0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("midrst_err", {31'd0, bus.err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        snap();
        run_to_done(1);
        read_all();

        // snap_req in DONE with cen held low stays in ARM
        snap();
        idle(20);
        check("arm_hold_state", {30'd0, fsm_state}, 32'd1);
        run_to_done(1);

        // Same-edge read/write of slot 2 returns the previous rotation's value
        snap();
        while (ring_slot != 0) beat(1, 0, 5'd0);
        beat(1, 0, 5'd0);
        beat(1, 0, 5'd0);
        check("collide_old_known", {31'd0, m_known[2]}, 32'd1);
        beat(1, 1, 5'd2);
        beat(1, 1, 5'd2);
        run_to_done(1);
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
